// File: rtl/tcm_dport_arbiter.sv
// Two-master round-robin arbiter for the single TCM data port, with an in-order
// owner FIFO that steers each TCM response back to the master that issued it.
module tcm_dport_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int TAG_W       = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic [31:0]      m0_addr_i,
    input  logic [31:0]      m0_data_wr_i,
    input  logic             m0_rd_i,
    input  logic [3:0]       m0_wr_i,
    input  logic [TAG_W-1:0] m0_req_tag_i,
    output logic             m0_accept_o,
    output logic             m0_ack_o,
    output logic             m0_error_o,
    output logic [31:0]      m0_data_rd_o,
    output logic [TAG_W-1:0] m0_resp_tag_o,

    input  logic [31:0]      m1_addr_i,
    input  logic [31:0]      m1_data_wr_i,
    input  logic             m1_rd_i,
    input  logic [3:0]       m1_wr_i,
    input  logic [TAG_W-1:0] m1_req_tag_i,
    output logic             m1_accept_o,
    output logic             m1_ack_o,
    output logic             m1_error_o,
    output logic [31:0]      m1_data_rd_o,
    output logic [TAG_W-1:0] m1_resp_tag_o,

    output logic [31:0]      s_addr_o,
    output logic [31:0]      s_data_wr_o,
    output logic             s_rd_o,
    output logic [3:0]       s_wr_o,
    output logic [TAG_W-1:0] s_req_tag_o,
    input  logic             s_accept_i,
    input  logic             s_ack_i,
    input  logic             s_error_i,
    input  logic [31:0]      s_data_rd_i,
    input  logic [TAG_W-1:0] s_resp_tag_i,

    output logic             unexp_ack_o,
    output logic [1:0][31:0] grant_cnt_o,
    output logic [1:0]       dbg_state_o
);

    // Request handshake: a master asserts rd/wr and holds address, data and tag
    // until it sees its accept; accept is combinational in the same cycle.
    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               hold_idx_q, hold_idx_d;
    logic               rr_ptr_q;

    logic               req0, req1;
    logic               grant_valid;
    logic               grant_idx;
    logic               full;
    logic               accept;

    logic [OUTSTANDING-1:0] owner_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push, pop, head;
    logic               ack_sel0, ack_sel1;

    assign req0   = m0_rd_i | (|m0_wr_i);
    assign req1   = m1_rd_i | (|m1_wr_i);
    assign full   = (count_q == CNT_W'(OUTSTANDING));
    assign accept = rst_ni & s_accept_i & grant_valid & ~full;

    assign dbg_state_o = {state_q == ST_HOLD, hold_idx_q};

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ARB;
            hold_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_idx_q <= hold_idx_d;
        end
    end

    // FSM: next state. A granted master that drops its request releases the hold.
    always_comb begin
        state_d    = state_q;
        hold_idx_d = hold_idx_q;
        case (state_q)
            ST_ARB: begin
                if (grant_valid && !accept) begin
                    state_d    = ST_HOLD;
                    hold_idx_d = grant_idx;
                end
            end
            ST_HOLD: begin
                if (accept || !grant_valid) begin
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // FSM: outputs (grant selection)
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        case (state_q)
            ST_ARB: begin
                grant_valid = req0 | req1;
                grant_idx   = (req0 && req1) ? rr_ptr_q : req1;
            end
            ST_HOLD: begin
                grant_idx   = hold_idx_q;
                grant_valid = hold_idx_q ? req1 : req0;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = 1'b0;
            end
        endcase
    end

    // Request mux toward the TCM; strobes are suppressed while the FIFO is full.
    always_comb begin
        s_addr_o    = '0;
        s_data_wr_o = '0;
        s_rd_o      = 1'b0;
        s_wr_o      = '0;
        s_req_tag_o = '0;
        if (rst_ni && grant_valid) begin
            if (grant_idx) begin
                s_addr_o    = m1_addr_i;
                s_data_wr_o = m1_data_wr_i;
                s_req_tag_o = m1_req_tag_i;
                s_rd_o      = m1_rd_i & ~full;
                s_wr_o      = full ? 4'h0 : m1_wr_i;
            end else begin
                s_addr_o    = m0_addr_i;
                s_data_wr_o = m0_data_wr_i;
                s_req_tag_o = m0_req_tag_i;
                s_rd_o      = m0_rd_i & ~full;
                s_wr_o      = full ? 4'h0 : m0_wr_i;
            end
        end
    end

    assign m0_accept_o = accept & ~grant_idx;
    assign m1_accept_o = accept & grant_idx;

    assign push = accept;
    assign pop  = rst_ni & s_ack_i & (count_q != '0);
    assign head = owner_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Response steering: only the head owner sees ack, data, tag and error.
    assign ack_sel0 = pop & ~head;
    assign ack_sel1 = pop & head;

    assign m0_ack_o      = ack_sel0;
    assign m0_error_o    = ack_sel0 & s_error_i;
    assign m0_data_rd_o  = ack_sel0 ? s_data_rd_i : 32'h0;
    assign m0_resp_tag_o = ack_sel0 ? s_resp_tag_i : '0;

    assign m1_ack_o      = ack_sel1;
    assign m1_error_o    = ack_sel1 & s_error_i;
    assign m1_data_rd_o  = ack_sel1 ? s_data_rd_i : 32'h0;
    assign m1_resp_tag_o = ack_sel1 ? s_resp_tag_i : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= 1'b0;
            unexp_ack_o <= 1'b0;
            grant_cnt_o <= '0;
        end else begin
            if (accept) begin
                rr_ptr_q               <= ~grant_idx;
                grant_cnt_o[grant_idx] <= grant_cnt_o[grant_idx] + 32'd1;
            end
            if (s_ack_i && (count_q == '0)) begin
                unexp_ack_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// Bench for tcm_dport_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a queue-based model of the arbitration and ownership rules.
module tb_tcm_dport_arbiter;
    localparam int OUT = 4;
    localparam int TW  = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_addr [2];
    logic [31:0] m_wdata[2];
    logic        m_rd   [2];
    logic [3:0]  m_wr   [2];
    logic [TW-1:0] m_tag[2];
    logic        acc    [2];
    logic        ack    [2];
    logic        err    [2];
    logic [31:0] rdata  [2];
    logic [TW-1:0] rtag [2];

    logic [31:0] s_addr, s_wdata;
    logic        s_rd;
    logic [3:0]  s_wr;
    logic [TW-1:0] s_tag;
    logic        s_accept = 1'b0, s_ack = 1'b0, s_error = 1'b0;
    logic [31:0] s_rdata = '0;
    logic [TW-1:0] s_rtag = '0;
    logic        unexp;
    logic [1:0][31:0] gcnt;
    logic [1:0]  dbg_state;

    tcm_dport_arbiter #(.OUTSTANDING(OUT), .TAG_W(TW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_addr_i(m_addr[0]), .m0_data_wr_i(m_wdata[0]), .m0_rd_i(m_rd[0]),
        .m0_wr_i(m_wr[0]), .m0_req_tag_i(m_tag[0]), .m0_accept_o(acc[0]),
        .m0_ack_o(ack[0]), .m0_error_o(err[0]), .m0_data_rd_o(rdata[0]),
        .m0_resp_tag_o(rtag[0]),
        .m1_addr_i(m_addr[1]), .m1_data_wr_i(m_wdata[1]), .m1_rd_i(m_rd[1]),
        .m1_wr_i(m_wr[1]), .m1_req_tag_i(m_tag[1]), .m1_accept_o(acc[1]),
        .m1_ack_o(ack[1]), .m1_error_o(err[1]), .m1_data_rd_o(rdata[1]),
        .m1_resp_tag_o(rtag[1]),
        .s_addr_o(s_addr), .s_data_wr_o(s_wdata), .s_rd_o(s_rd), .s_wr_o(s_wr),
        .s_req_tag_o(s_tag), .s_accept_i(s_accept), .s_ack_i(s_ack),
        .s_error_i(s_error), .s_data_rd_i(s_rdata), .s_resp_tag_i(s_rtag),
        .unexp_ack_o(unexp), .grant_cnt_o(gcnt), .dbg_state_o(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner queue, round-robin favourite, held grant (-1 = none), counters.
    int          own_q[$];
    int          rr_m = 0;
    int          held_m = -1;
    logic [31:0] cnt_m[2];
    bit          unexp_m = 0;

    int g, owner;
    bit gv, full_m, acc_e, ackv;
    bit req_m[2];

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_strobes", {s_rd, s_wr, acc[0], acc[1], ack[0], ack[1], err[0], err[1], unexp}, 0);
            chk("rst_s_bus", {s_addr, s_wdata}, 0);
            chk("rst_resp", {rdata[0], rdata[1]}, 0);
            chk("rst_tags", {s_tag, rtag[0], rtag[1]}, 0);
            chk("rst_gcnt", {gcnt[1], gcnt[0]}, 0);
            own_q.delete();
            rr_m = 0; held_m = -1; cnt_m[0] = 0; cnt_m[1] = 0; unexp_m = 0;
        end else begin
            for (int i = 0; i < 2; i++) req_m[i] = m_rd[i] | (|m_wr[i]);
            full_m = (own_q.size() == OUT);
            if (held_m >= 0) begin
                g  = held_m;
                gv = req_m[g];
            end else begin
                gv = req_m[0] | req_m[1];
                g  = (req_m[0] && req_m[1]) ? rr_m : (req_m[1] ? 1 : 0);
            end
            acc_e = s_accept && gv && !full_m;
            chk("s_addr", s_addr, gv ? m_addr[g] : 32'h0);
            chk("s_data_wr", s_wdata, gv ? m_wdata[g] : 32'h0);
            chk("s_req_tag", s_tag, gv ? m_tag[g] : '0);
            chk("s_rd", s_rd, gv && !full_m && m_rd[g]);
            chk("s_wr", s_wr, (gv && !full_m) ? m_wr[g] : 4'h0);
            ackv  = s_ack && (own_q.size() > 0);
            owner = ackv ? own_q[0] : -1;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m%0d_accept", i), acc[i], acc_e && (g == i));
                chk($sformatf("m%0d_ack", i), ack[i], owner == i);
                chk($sformatf("m%0d_error", i), err[i], (owner == i) && s_error);
                chk($sformatf("m%0d_data_rd", i), rdata[i], (owner == i) ? s_rdata : 32'h0);
                chk($sformatf("m%0d_resp_tag", i), rtag[i], (owner == i) ? s_rtag : '0);
                chk($sformatf("grant_cnt%0d", i), gcnt[i], cnt_m[i]);
            end
            chk("unexp_ack", unexp, unexp_m);
            if (s_ack && own_q.size() == 0) unexp_m = 1;
            if (ackv) void'(own_q.pop_front());
            if (acc_e) begin
                own_q.push_back(g);
                cnt_m[g] = cnt_m[g] + 32'd1;
                rr_m = 1 - g;
            end
            held_m = (gv && !acc_e) ? g : -1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            m_rd[i] = 0; m_wr[i] = 0; m_addr[i] = 0; m_wdata[i] = 0; m_tag[i] = 0;
        end
        s_accept = 0; s_ack = 0; s_error = 0; s_rdata = 0; s_rtag = 0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 0;
        idle();
        step();
        step();
        rst_n = 1;
    endtask

    int n_acc;
    int ord[$];

    initial begin
        idle();
        step();
        rst_n = 1;

        // 1: lone m0 read, accepted at once, acked the following cycle
        do_reset();
        step();
        m_rd[0] = 1; m_addr[0] = 32'h8000_0100; m_tag[0] = 11'h123; s_accept = 1;
        #1;
        chk("t1_m0_accept", acc[0], 1);
        chk("t1_m1_accept", acc[1], 0);
        chk("t1_s_addr", s_addr, 32'h8000_0100);
        step();
        m_rd[0] = 0; s_accept = 0; s_ack = 1; s_rdata = 32'hCAFE_F00D; s_rtag = 11'h123;
        #1;
        chk("t1_m0_ack", ack[0], 1);
        chk("t1_m0_data", rdata[0], 32'hCAFE_F00D);
        chk("t1_m0_tag", rtag[0], 11'h123);
        chk("t1_m1_quiet", {ack[1], rdata[1], rtag[1]}, 0);
        chk("t1_gcnt0", gcnt[0], 1);
        step();
        idle();

        // 2: both masters always requesting, TCM always accepting
        do_reset();
        for (int k = 0; k < 100; k++) begin
            step();
            m_rd[0] = 1; m_addr[0] = 32'h8000_0000 + 32'(k);
            m_rd[1] = 1; m_addr[1] = 32'h8000_4000 + 32'(k);
            s_accept = 1;
            s_ack = (own_q.size() > 0);
            s_rdata = $urandom; s_rtag = TW'($urandom);
            #1;
            if (k < 4) chk("t2_alternate", acc[1], k % 2);
        end
        step();
        idle();
        s_ack = 1;
        #1;
        chk("t2_gcnt0", gcnt[0], 50);
        chk("t2_gcnt1", gcnt[1], 50);
        step();
        idle();

        // 3: m1 write stalled by TCM for 5 cycles while m0 waits
        do_reset();
        step();
        m_wr[1] = 4'hF; m_addr[1] = 32'h8000_9000; m_wdata[1] = 32'h1234_5678; m_tag[1] = 11'h7;
        m_addr[0] = 32'h8000_0200; m_tag[0] = 11'h2;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) m_rd[0] = 1;
            #1;
            chk("t3_hold_addr", s_addr, 32'h8000_9000);
            chk("t3_hold_wr", s_wr, 4'hF);
            step();
        end
        s_accept = 1;
        #1;
        chk("t3_m1_accept", {acc[1], acc[0]}, 2'b10);
        step();
        m_wr[1] = 0;
        #1;
        chk("t3_m0_next", {acc[0], s_rd}, 2'b11);
        chk("t3_m0_addr", s_addr, 32'h8000_0200);
        step();
        idle();
        s_ack = 1;
        step();
        step();
        idle();

        // 4: acks withheld, FIFO fills at OUT, then responses drain in issue order
        do_reset();
        step();
        m_rd[0] = 1; m_rd[1] = 1; s_accept = 1;
        n_acc = 0;
        ord.delete();
        for (int c = 0; c < 8; c++) begin
            #1;
            if (acc[0]) begin n_acc++; ord.push_back(0); end
            if (acc[1]) begin n_acc++; ord.push_back(1); end
            step();
        end
        #1;
        chk("t4_accepts", n_acc, 4);
        chk("t4_full_rd", s_rd, 0);
        step();
        m_rd[0] = 0; m_rd[1] = 0; s_accept = 0; s_ack = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t4_ack_order", {ack[1], ack[0]}, (c % 2 == 0) ? 2'b01 : 2'b10);
            step();
        end
        idle();

        // 5: ack on empty FIFO is sticky; reset mid-burst clears everything at once
        do_reset();
        step();
        s_ack = 1;
        #1;
        chk("t5_no_ack", {ack[1], ack[0]}, 0);
        step();
        s_ack = 0;
        #1;
        chk("t5_unexp", unexp, 1);
        step();
        step();
        #1;
        chk("t5_unexp_sticky", unexp, 1);
        for (int c = 0; c < 6; c++) begin
            step();
            m_rd[0] = 1; m_rd[1] = 1; s_accept = 1; s_ack = (own_q.size() > 0);
        end
        step();
        rst_n = 0;
        #1;
        chk("t5_rst_now", {s_rd, acc[0], acc[1], unexp}, 0);
        chk("t5_rst_gcnt", {gcnt[1], gcnt[0]}, 0);
        step();
        rst_n = 1;
        m_rd[0] = 0; m_rd[1] = 0; s_accept = 0; s_ack = 1;
        #1;
        chk("t5_late_ack", {ack[1], ack[0]}, 0);
        step();
        s_ack = 0; m_rd[0] = 1; m_rd[1] = 1; s_accept = 1;
        #1;
        chk("t5_late_unexp", unexp, 1);
        chk("t5_rr_m0", {acc[1], acc[0]}, 2'b01);
        step();
        idle();
        s_ack = 1;
        step();
        idle();

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            step();
            rst_n = ($urandom_range(0, 999) != 0);
            for (int i = 0; i < 2; i++) begin
                m_rd[i]    = ($urandom_range(0, 2) == 0);
                m_wr[i]    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                m_addr[i]  = $urandom;
                m_wdata[i] = $urandom;
                m_tag[i]   = TW'($urandom);
            end
            s_accept = ($urandom_range(0, 3) != 0);
            s_ack    = (own_q.size() > 0) ? ($urandom_range(0, 2) != 0)
                                          : ($urandom_range(0, 499) == 0);
            s_error  = ($urandom_range(0, 7) == 0);
            s_rdata  = $urandom;
            s_rtag   = TW'($urandom);
        end
        step();
        rst_n = 1;
        idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
